fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 118 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Two-byte instruction fetcher. It reads an opcode byte and then an operand byte over a
// simple req/ack memory port, and holds the assembled instruction until the decoder takes it.
module fetch_unit #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        branch_en,
  input  logic [7:0]  branch_target,
  output logic        mem_req,
  output logic [7:0]  mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] instr,
  output logic [7:0]  instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [7:0]  pc
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH0 = 2'd1,
    FETCH1 = 2'd2,
    VALID  = 2'd3
  } state_t;

  state_t      state_q;
  logic [7:0]  pc_q;
  logic        mem_req_q;
  logic [7:0]  mem_addr_q;
  logic [15:0] instr_q;
  logic [7:0]  instr_pc_q;
  logic        instr_valid_q;

  logic [7:0]  pc_plus1_d;
  logic [7:0]  pc_plus2_d;

  // The 8-bit adds wrap naturally from 8'hFF to 8'h00.
  assign pc_plus1_d = pc_q + 8'd1;
  assign pc_plus2_d = pc_q + 8'd2;

  // All outputs are registered. mem_req and mem_addr are set when a fetch state is entered,
  // so they stay constant for as long as the fetch waits for its ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= RESET_PC;
      instr_q       <= 16'h0000;
      instr_pc_q    <= RESET_PC;
      instr_valid_q <= 1'b0;
    end else if (branch_en) begin
      // A redirect drops any partial or held instruction and ignores a coincident ack.
      pc_q          <= branch_target;
      mem_addr_q    <= branch_target;
      instr_valid_q <= 1'b0;
      if (run) begin
        state_q   <= FETCH0;
        mem_req_q <= 1'b1;
      end else begin
        state_q   <= IDLE;
        mem_req_q <= 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (run) begin
            state_q    <= FETCH0;
            mem_req_q  <= 1'b1;
            mem_addr_q <= pc_q;
          end
        end
        FETCH0: begin
          if (mem_ack) begin
            instr_q[15:8] <= mem_rdata;
            instr_pc_q    <= pc_q;
            mem_addr_q    <= pc_plus1_d;
            state_q       <= FETCH1;
          end
        end
        FETCH1: begin
          if (mem_ack) begin
            instr_q[7:0]  <= mem_rdata;
            pc_q          <= pc_plus2_d;
            mem_req_q     <= 1'b0;
            instr_valid_q <= 1'b1;
            state_q       <= VALID;
          end
        end
        VALID: begin
          // run is sampled only here, so clearing it never cuts a fetch short.
          if (instr_ready) begin
            instr_valid_q <= 1'b0;
            if (run) begin
              state_q    <= FETCH0;
              mem_req_q  <= 1'b1;
              mem_addr_q <= pc_q;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;

endmodule
